hex_display_scanner: RTL and testbench
======================================

# hex_display_scanner

Parametrised successor to the nibble splitter in the seven-segment path. Captures an N-digit hex value plus decimal points and time-multiplexes it onto a common-anode display, one digit per refresh slot. Drives the anode selects and segment lines directly on the Basys 3 display. Double-buffers the value so updates never tear mid-frame. Sits between the mouse/car status registers and the board pins.

## Interface
- N_DIGITS, 4: digits scanned; legal 1..8.
- REFRESH_DIV, 100000: CLK cycles per digit slot; legal >= 2. At 100 MHz the default gives 1 kHz per digit.
- ACTIVE_LOW, 1: when 1, anode and segment outputs are active-low; when 0, active-high.
- CLK  in  1  system clock, rising edge.
- RESETN  in  1  asynchronous active-low reset.
- DATA_IN  in  4*N_DIGITS  hex value; nibble i drives digit i, digit 0 is rightmost.
- DP_IN  in  N_DIGITS  decimal point per digit; 1 means lit.
- LOAD  in  1  single-cycle strobe that samples DATA_IN and DP_IN.
- ENABLE  in  1  when 0, all digits are dark; scanning and loading continue.
- SEG_SELECT_OUT  out  N_DIGITS  one-hot anode select, polarity per ACTIVE_LOW.
- HEX_OUT  out  8  {dp,g,f,e,d,c,b,a}, polarity per ACTIVE_LOW.
- FRAME_DONE  out  1  one-cycle pulse at each frame wrap.

## Operation
- Registers:
  - slot counter `cnt`, width $clog2(REFRESH_DIV)
  - digit index `idx`, width max(1,$clog2(N_DIGITS))
  - shadow register `shd` (data + dp)
  - display register `dsp` (data + dp)
  - `pending` flag
- Tick: asserted when `cnt == REFRESH_DIV-1`. On tick, `cnt` returns to 0; otherwise it increments.
- On tick, `idx` increments modulo N_DIGITS. A tick with `idx == N_DIGITS-1` is a frame wrap.
- LOAD=1: `shd` <= {DATA_IN, DP_IN} and `pending` <= 1. LOAD held high for several cycles reloads on every cycle; the last sample wins.
- Frame wrap with `pending`=1: `dsp` <= `shd` and `pending` <= 0. Without `pending`, `dsp` holds.
- LOAD coinciding with a frame wrap:
  - `dsp` takes the old `shd` contents.
  - `shd` takes the new sample.
  - `pending` stays 1, so the new value commits at the next wrap.
- Segment decode (active-high view):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - dp is bit 7.
- Output registers, updated every cycle from the current `idx` and `dsp`:
  - SEG_SELECT_OUT = one-hot(`idx`)
  - HEX_OUT = decode(`dsp` nibble `idx`) with dp
  - When ACTIVE_LOW=1, both outputs are inverted.
- ENABLE=0: both outputs are driven to the inactive level (all 1s when ACTIVE_LOW=1). `cnt`, `idx`, `shd`, `dsp` and FRAME_DONE behave normally.
- Reset (asynchronous, RESETN=0):
  - `cnt`, `idx`, `shd`, `dsp`, `pending` and FRAME_DONE are all 0.
  - SEG_SELECT_OUT and HEX_OUT are at the inactive level.
  - A reset mid-frame discards any pending load.

## Timing
- SEG_SELECT_OUT and HEX_OUT lag `idx` and `dsp` by one cycle (registered).
- The first output after reset release is digit 0, showing value 0, on the first rising edge.
- Each digit is lit for exactly REFRESH_DIV cycles. A full frame is N_DIGITS*REFRESH_DIV cycles.
- FRAME_DONE is high for the one cycle after the wrap edge, aligned with the `dsp` update.
- LOAD-to-visible latency:
  - minimum 2 cycles (LOAD one cycle before a wrap);
  - maximum N_DIGITS*REFRESH_DIV+1 cycles.
- N_DIGITS=1: every tick is a wrap; SEG_SELECT_OUT is constantly active while enabled.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digit i (i >= 1) is blanked when nibble i and all higher nibbles of `dsp` are 0.
  - A blanked digit still shows its dp bit.
  - Digit 0 is never blanked.
- Undefined: all digits always display, including leading zeros.

## Structure
- Package `seg7_pkg`:
  - the 16 active-high segment constants and the dp bit position;
  - typedef `seg_t` (8 bits);
  - function for the one-hot anode pattern.
- Sub-module `hex_to_seg7`: 4-bit nibble in, 7-bit active-high segments out, purely combinational. It is instantiated once, fed by the `idx` mux.

## Test plan
Parameters for all scenarios: N_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1.
- Reset, then RESETN=1, ENABLE=1 -> SEG_SELECT_OUT cycles E,D,B,7 (4 cycles each). HEX_OUT=C0 throughout. FRAME_DONE pulses every 16 cycles.
- LOAD with DATA_IN=16'h1A2F, DP_IN=4'b0010 -> after the next wrap, digits 0..3 show 8E, 24 (dp lit), 88, F9. No change is visible before the wrap.
- LOAD 16'h1111 mid-frame, then LOAD 16'h2222 at the wrap cycle -> first wrap commits 1111. The next wrap commits 2222.
- ENABLE=0 for one frame -> SEG_SELECT_OUT=F and HEX_OUT=FF. FRAME_DONE still pulses. On re-enable, display resumes in phase.
- RESETN asserted mid-frame with a pending load -> outputs go inactive immediately. After release, the display shows 0000 (HEX_OUT=C0).
- With LEADING_ZERO_BLANK_EN, load 16'h0030 -> digits 3 and 2 show FF, digit 1 shows B0, digit 0 shows C0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-high glyph constants, the dp bit
// position, the segment byte type and the anode one-hot helper.
package seg7_pkg;

  typedef logic [7:0] seg_t;

  localparam int unsigned DP_BIT = 7;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // Active-high anode pattern for up to eight digits; callers truncate.
  function automatic logic [7:0] anode_onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high {g,f,e,d,c,b,a} segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_c
);

  always_comb begin
    o_seg_c = 7'h00;
    case (i_nibble)
      4'h0: o_seg_c = SEG_0;
      4'h1: o_seg_c = SEG_1;
      4'h2: o_seg_c = SEG_2;
      4'h3: o_seg_c = SEG_3;
      4'h4: o_seg_c = SEG_4;
      4'h5: o_seg_c = SEG_5;
      4'h6: o_seg_c = SEG_6;
      4'h7: o_seg_c = SEG_7;
      4'h8: o_seg_c = SEG_8;
      4'h9: o_seg_c = SEG_9;
      4'hA: o_seg_c = SEG_A;
      4'hB: o_seg_c = SEG_B;
      4'hC: o_seg_c = SEG_C;
      4'hD: o_seg_c = SEG_D;
      4'hE: o_seg_c = SEG_E;
      4'hF: o_seg_c = SEG_F;
      default: o_seg_c = 7'h00;
    endcase
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Double-buffered N-digit hex scanner for a multiplexed seven-segment display.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module hex_display_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [4*N_DIGITS-1:0] DATA_IN,
  input  logic [N_DIGITS-1:0]   DP_IN,
  input  logic                  LOAD,
  input  logic                  ENABLE,
  output logic [N_DIGITS-1:0]   SEG_SELECT_OUT,
  output seg_t                  HEX_OUT,
  output logic                  FRAME_DONE
);

  localparam int unsigned DATA_W   = 4 * N_DIGITS;
  localparam int unsigned CNT_W    = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic        INACTIVE = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_shd_data;
  logic [N_DIGITS-1:0] r_shd_dp;
  logic [DATA_W-1:0]   r_dsp_data;
  logic [N_DIGITS-1:0] r_dsp_dp;
  logic                r_pending;

  logic                w_tick;
  logic                w_last_digit;
  logic                w_wrap;
  logic [3:0]          w_nibble;
  logic                w_dp;
  logic [6:0]          w_seg7;
  logic                w_blank;
  logic [N_DIGITS-1:0] w_sel_nxt;
  seg_t                w_hex_nxt;

  assign w_tick       = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_last_digit = (r_idx == IDX_W'(N_DIGITS - 1));
  assign w_wrap       = w_tick && w_last_digit;

  // Select the nibble and dp of the digit currently being scanned.
  always_comb begin
    w_nibble = 4'h0;
    w_dp     = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nibble = r_dsp_data[4*i +: 4];
        w_dp     = r_dsp_dp[i];
      end
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble (w_nibble),
    .o_seg_c  (w_seg7)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] w_upper_zero;
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_upper_zero
    assign w_upper_zero[g] = (r_dsp_data[DATA_W-1:4*g] == '0);
  end
  assign w_blank = (r_idx != '0) && w_upper_zero[r_idx];
`else
  assign w_blank = 1'b0;
`endif

  // Build the active-high view, then apply the board polarity.
  always_comb begin
    w_sel_nxt = '0;
    w_hex_nxt = '0;
    if (ENABLE) begin
      w_sel_nxt          = N_DIGITS'(anode_onehot(3'(r_idx)));
      w_hex_nxt[6:0]     = w_blank ? 7'h00 : w_seg7;
      w_hex_nxt[DP_BIT]  = w_dp;
    end
    if (INACTIVE) begin
      w_sel_nxt = ~w_sel_nxt;
      w_hex_nxt = ~w_hex_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_cnt          <= '0;
      r_idx          <= '0;
      r_shd_data     <= '0;
      r_shd_dp       <= '0;
      r_dsp_data     <= '0;
      r_dsp_dp       <= '0;
      r_pending      <= 1'b0;
      FRAME_DONE     <= 1'b0;
      SEG_SELECT_OUT <= {N_DIGITS{INACTIVE}};
      HEX_OUT        <= {8{INACTIVE}};
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
      if (w_tick) begin
        r_idx <= w_last_digit ? '0 : r_idx + IDX_W'(1);
      end
      if (LOAD) begin
        r_shd_data <= DATA_IN;
        r_shd_dp   <= DP_IN;
      end
      // Commit uses the pre-load shadow; a coincident LOAD keeps pending set.
      if (w_wrap && r_pending) begin
        r_dsp_data <= r_shd_data;
        r_dsp_dp   <= r_shd_dp;
      end
      r_pending      <= LOAD || (r_pending && !w_wrap);
      FRAME_DONE     <= w_wrap;
      SEG_SELECT_OUT <= w_sel_nxt;
      HEX_OUT        <= w_hex_nxt;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomized self-checking bench for hex_display_scanner against a cycle-count
// based reference model (N_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1).
module tb_hex_display_scanner;

  localparam int N     = 4;
  localparam int RD    = 4;
  localparam int FRAME = N * RD;

  logic        CLK;
  logic        RESETN;
  logic [15:0] DATA_IN;
  logic [3:0]  DP_IN;
  logic        LOAD;
  logic        ENABLE;
  logic [3:0]  SEG_SELECT_OUT;
  logic [7:0]  HEX_OUT;
  logic        FRAME_DONE;

  int n_tests;
  int n_fail;

  // Reference state: edges since reset release, shadow, display, pending.
  int          m_k;
  logic [15:0] m_shd_d;
  logic [3:0]  m_shd_dp;
  logic [15:0] m_dsp_d;
  logic [3:0]  m_dsp_dp;
  logic        m_pend;
  logic [6:0]  seg_tbl [16];

  hex_display_scanner #(
    .N_DIGITS    (N),
    .REFRESH_DIV (RD),
    .ACTIVE_LOW  (1)
  ) dut (
    .CLK            (CLK),
    .RESETN         (RESETN),
    .DATA_IN        (DATA_IN),
    .DP_IN          (DP_IN),
    .LOAD           (LOAD),
    .ENABLE         (ENABLE),
    .SEG_SELECT_OUT (SEG_SELECT_OUT),
    .HEX_OUT        (HEX_OUT),
    .FRAME_DONE     (FRAME_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k      = 0;
    m_shd_d  = '0;
    m_shd_dp = '0;
    m_dsp_d  = '0;
    m_dsp_dp = '0;
    m_pend   = 1'b0;
  endtask

  // Drive one cycle of inputs, then check outputs just after the edge.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] dp, input logic en);
    int         dig;
    logic [3:0] nib;
    logic [3:0] sel;
    logic [7:0] hex;
    logic       wrap;
    logic       blank;
    LOAD    = ld;
    DATA_IN = d;
    DP_IN   = dp;
    ENABLE  = en;
    @(posedge CLK);
    #1;
    m_k++;
    dig  = ((m_k - 1) / RD) % N;
    wrap = ((m_k % FRAME) == 0);
    if (en) begin
      nib   = 4'(m_dsp_d >> (4 * dig));
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank = (dig != 0) && ((m_dsp_d >> (4 * dig)) == 16'h0000);
`endif
      hex = ~{m_dsp_dp[dig], (blank ? 7'h00 : seg_tbl[nib])};
      sel = ~4'(1 << dig);
    end else begin
      hex = 8'hFF;
      sel = 4'hF;
    end
    check_eq("sel", 32'(SEG_SELECT_OUT), 32'(sel));
    check_eq("hex", 32'(HEX_OUT), 32'(hex));
    check_eq("frame_done", 32'(FRAME_DONE), 32'(wrap));
    if (wrap && m_pend) begin
      m_dsp_d  = m_shd_d;
      m_dsp_dp = m_shd_dp;
      m_pend   = 1'b0;
    end
    if (ld) begin
      m_shd_d  = d;
      m_shd_dp = dp;
      m_pend   = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0000, 4'h0, 1'b1);
  endtask

  initial begin
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    n_tests = 0;
    n_fail  = 0;
    RESETN  = 1'b0;
    LOAD    = 1'b0;
    ENABLE  = 1'b1;
    DATA_IN = '0;
    DP_IN   = '0;
    model_reset();

    repeat (2) @(posedge CLK);
    #1;
    check_eq("reset_sel", 32'(SEG_SELECT_OUT), 32'h0000000F);
    check_eq("reset_hex", 32'(HEX_OUT), 32'h000000FF);
    check_eq("reset_frame_done", 32'(FRAME_DONE), 32'h0);
    RESETN = 1'b1;

    idle(40);

    // Load mid-frame; nothing may change until the wrap.
    idle(3);
    step(1'b1, 16'h1A2F, 4'b0010, 1'b1);
    idle(40);

    // Mid-frame load followed by a load on the wrap edge itself.
    while (((m_k + 1) % FRAME) != 5) idle(1);
    step(1'b1, 16'h1111, 4'h0, 1'b1);
    while (((m_k + 1) % FRAME) != 0) idle(1);
    step(1'b1, 16'h2222, 4'h0, 1'b1);
    idle(2 * FRAME + 4);

    // One dark frame, then resume.
    while ((m_k % FRAME) != 0) idle(1);
    repeat (FRAME) step(1'b0, 16'h0000, 4'h0, 1'b0);
    idle(FRAME);

    // Leading zeros.
    step(1'b1, 16'h0030, 4'h0, 1'b1);
    idle(2 * FRAME);

    // Random loads, data, dp and enable.
    repeat (600) step(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom),
                      ($urandom_range(0, 9) != 0));

    // LOAD held for several cycles: the last sample wins.
    repeat (5) step(1'b1, 16'($urandom), 4'($urandom), 1'b1);
    idle(2 * FRAME);

    // Asynchronous reset mid-frame with a load still pending.
    while ((m_k % FRAME) != 6) idle(1);
    step(1'b1, 16'hBEEF, 4'hF, 1'b1);
    idle(2);
    LOAD   = 1'b0;
    RESETN = 1'b0;
    #1;
    check_eq("async_reset_sel", 32'(SEG_SELECT_OUT), 32'h0000000F);
    check_eq("async_reset_hex", 32'(HEX_OUT), 32'h000000FF);
    check_eq("async_reset_frame_done", 32'(FRAME_DONE), 32'h0);
    model_reset();
    @(posedge CLK);
    #1;
    check_eq("held_reset_sel", 32'(SEG_SELECT_OUT), 32'h0000000F);
    check_eq("held_reset_hex", 32'(HEX_OUT), 32'h000000FF);
    RESETN = 1'b1;
    idle(2 * FRAME + 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
